icache_fill_ctrl: RTL



---
 rtl/icache_fill_ctrl_pkg.sv | 19 +
 rtl/icache_fill_ctrl_if.sv | 23 ++
 rtl/icache_fill_ctrl_perf_ctr.sv | 21 ++
 rtl/icache_fill_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/icache_fill_ctrl_pkg.sv
// Shared I-cache types and geometry, used by the fill controller and the cache.
package icache_pkg;

    localparam int BLOCK_WORDS      = 4;
    localparam int INDEX_SIZE       = 4;
    localparam int WORD_OFFSET_SIZE = 2;
    localparam int BYTE_OFFSET_SIZE = 2;
    localparam int TAG_SIZE         = 32 - INDEX_SIZE
                                      - WORD_OFFSET_SIZE
                                      - BYTE_OFFSET_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        UPDATE,
        SETTLE
    } fill_state_t;

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// Instruction-memory read port: one outstanding request, valid-qualified data.
interface icache_fill_ctrl_if;

    logic        mem_rden;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    modport master (
        output mem_rden,
        output mem_addr,
        input  mem_rdata,
        input  mem_valid
    );

    modport slave (
        input  mem_rden,
        input  mem_addr,
        output mem_rdata,
        output mem_valid
    );

endinterface

// File: rtl/icache_fill_ctrl_perf_ctr.sv
// Generic 32-bit enable counter, wraps modulo 2^32.
module icache_perf_ctr (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/icache_fill_ctrl.sv
// I-cache miss handler and 4-word line fill controller.
// Optional ICACHE_FILL_PERF_EN adds fill_count/stall_count counters.
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int BLOCK_WORDS = 4,
    parameter int OFFSET_BITS = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      miss,
    input  logic [31:0]               pc,
    output logic                      cacheStall,
    output logic                      update,
    output logic [31:0]               w0,
    output logic [31:0]               w1,
    output logic [31:0]               w2,
    output logic [31:0]               w3,
    icache_fill_ctrl_if.master        mem
`ifdef ICACHE_FILL_PERF_EN
   ,output logic [31:0]               fill_count,
    output logic [31:0]               stall_count
`endif
);

    localparam int LINE_W = 32 - OFFSET_BITS;

    fill_state_t       state_q;
    logic [1:0]        cnt_q;
    logic [LINE_W-1:0] line_q;
    logic [3:0][31:0]  buf_q;
    logic [3:0][31:0]  buf_d;
    logic [3:0][31:0]  w_q;
    logic              update_q;
    logic              rden_q;
    logic [31:0]       addr_q;
    logic              last_word;
    logic              fill_done;
    logic              unused_pc;

    assign last_word = (cnt_q == 2'(BLOCK_WORDS - 1));
    assign fill_done = (state_q == REQ) && mem.mem_valid && last_word;
    assign unused_pc = ^pc[OFFSET_BITS-1:0];

    always_comb begin
        buf_d = buf_q;
        if (state_q == REQ && mem.mem_valid) begin
            buf_d[cnt_q] = mem.mem_rdata;
        end
    end

    // Address is the latched line with the word index spliced in.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            line_q   <= '0;
            buf_q    <= '0;
            w_q      <= '0;
            update_q <= 1'b0;
            rden_q   <= 1'b0;
            addr_q   <= '0;
        end else begin
            update_q <= 1'b0;
            buf_q    <= buf_d;
            unique case (state_q)
                IDLE: begin
                    if (miss) begin
                        line_q  <= pc[31:OFFSET_BITS];
                        cnt_q   <= '0;
                        rden_q  <= 1'b1;
                        addr_q  <= {pc[31:OFFSET_BITS], 4'b0000};
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (fill_done) begin
                        rden_q   <= 1'b0;
                        update_q <= 1'b1;
                        w_q      <= buf_d;
                        state_q  <= UPDATE;
                    end else if (mem.mem_valid) begin
                        cnt_q  <= cnt_q + 2'd1;
                        addr_q <= {line_q, cnt_q + 2'd1, 2'b00};
                    end
                end
                UPDATE: state_q <= SETTLE;
                SETTLE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall covers the miss cycle itself; miss never depends on cacheStall.
    assign cacheStall   = (state_q != IDLE) | miss;
    assign update       = update_q;
    assign w0           = w_q[0];
    assign w1           = w_q[1];
    assign w2           = w_q[2];
    assign w3           = w_q[3];
    assign mem.mem_rden = rden_q;
    assign mem.mem_addr = addr_q;

`ifdef ICACHE_FILL_PERF_EN
    icache_perf_ctr u_fill_ctr (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (fill_done),
        .count_o (fill_count)
    );

    icache_perf_ctr u_stall_ctr (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (cacheStall),
        .count_o (stall_count)
    );
`endif

endmodule
